regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port among several writeback requesters (ALU, load unit, multiply/divide) and tracks registers with outstanding long-latency writes. Sits between the execute/memory stages and the register file; drives its `we`/`windex`/`win` inputs from a registered output stage. It also answers decode-stage busy queries so that issue logic can stall on RAW hazards against in-flight results.

---
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with a busy scoreboard for long-latency writes.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority (lowest index wins).
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_index,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rsv_valid,
  input  logic [4:0]           rsv_index,
  input  logic [4:0]           q0_index,
  input  logic [4:0]           q1_index,
  output logic                 q0_busy,
  output logic                 q1_busy,
  output logic                 rf_we,
  output logic [4:0]           rf_windex,
  output logic [31:0]          rf_win,
  output logic [CNTW-1:0]      contention_cnt
);

  logic [NREQ-1:0] w_gnt;
  logic            w_xfer;
  logic [4:0]      w_windex;
  logic [31:0]     w_wdata;
  logic            w_multi;
  logic [31:0]     r_busy;
  logic [31:0]     w_busy_nxt;

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    int w_i;
    w_gnt  = '0;
    w_gidx = '0;
    w_i    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_i = int'(r_ptr) + k;
      if (w_i >= NREQ) w_i = w_i - NREQ;
      if (req_valid[w_i] && (w_gnt == '0)) begin
        w_gnt[w_i] = 1'b1;
        w_gidx     = PW'(w_i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= '0;
    else if (w_xfer)
      r_ptr <= (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
  end
`else
  // Scan high to low so the lowest valid requester is the last to claim the grant.
  always_comb begin
    w_gnt = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_gnt    = '0;
        w_gnt[k] = 1'b1;
      end
    end
  end
`endif

  assign req_ready = w_gnt;
  assign w_xfer    = |w_gnt;
  assign w_multi   = ($countones(req_valid) >= 2);

  always_comb begin
    w_windex = '0;
    w_wdata  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_windex = w_windex | (req_index[5*k +: 5]  & {5{w_gnt[k]}});
      w_wdata  = w_wdata  | (req_data[32*k +: 32] & {32{w_gnt[k]}});
    end
  end

  // Clear first so a same-cycle reserve of the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer)    w_busy_nxt[w_windex]  = 1'b0;
    if (rsv_valid) w_busy_nxt[rsv_index] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  assign q0_busy = r_busy[q0_index];
  assign q1_busy = r_busy[q1_index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy         <= '0;
      rf_we          <= 1'b0;
      rf_windex      <= '0;
      rf_win         <= '0;
      contention_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      // r0 writes are accepted (grant, scoreboard) but never reach the file.
      rf_we  <= w_xfer && (w_windex != 5'd0);
      if (w_xfer) begin
        rf_windex <= w_windex;
        rf_win    <= w_wdata;
      end
      if (w_multi && !(&contention_cnt))
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a behavioural model of the arbitration,
// scoreboard and counter rules; a second instance with CNTW=4 exercises counter saturation.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_index;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready, req_ready4;
  logic               rsv_valid;
  logic [4:0]         rsv_index, q0_index, q1_index;
  logic               q0_busy, q1_busy, q0_busy4, q1_busy4;
  logic               rf_we, rf_we4;
  logic [4:0]         rf_windex, rf_windex4;
  logic [31:0]        rf_win, rf_win4;
  logic [15:0]        contention_cnt;
  logic [3:0]         contention_cnt4;

  logic [4:0]  t_idx [NREQ];
  logic [31:0] t_dat [NREQ];

  always_comb begin
    req_index = '0;
    req_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_index[5*k +: 5]  = t_idx[k];
      req_data[32*k +: 32] = t_dat[k];
    end
  end

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index), .req_data(req_data),
    .req_ready(req_ready), .rsv_valid(rsv_valid), .rsv_index(rsv_index),
    .q0_index(q0_index), .q1_index(q1_index), .q0_busy(q0_busy), .q1_busy(q1_busy),
    .rf_we(rf_we), .rf_windex(rf_windex), .rf_win(rf_win), .contention_cnt(contention_cnt));

  regfile_wb_arbiter #(.NREQ(NREQ), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index), .req_data(req_data),
    .req_ready(req_ready4), .rsv_valid(rsv_valid), .rsv_index(rsv_index),
    .q0_index(q0_index), .q1_index(q1_index), .q0_busy(q0_busy4), .q1_busy(q1_busy4),
    .rf_we(rf_we4), .rf_windex(rf_windex4), .rf_win(rf_win4), .contention_cnt(contention_cnt4));

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [31:0] m_busy;
  int        m_p;
  bit        m_we;
  bit [4:0]  m_idx;
  bit [31:0] m_win;
  int        m_cnt, m_cnt4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mgrant(input logic [NREQ-1:0] v);
`ifdef WB_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NREQ; k++)
      if (v[(m_p + k) % NREQ]) return (m_p + k) % NREQ;
`else
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_p = 0; m_we = 0; m_idx = '0; m_win = '0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic idle_inputs();
    req_valid = '0; rsv_valid = 0; rsv_index = '0; q0_index = '0; q1_index = '0;
    for (int k = 0; k < NREQ; k++) begin t_idx[k] = '0; t_dat[k] = '0; end
  endtask

  // One clock: check combinational outputs at the negedge, registered outputs 1ns after the posedge.
  task automatic tick();
    int g;
    logic [NREQ-1:0] v, exp_rdy;
    logic [4:0]  ix [NREQ];
    logic [31:0] dt [NREQ];
    logic rv;
    logic [4:0] ri;
    @(negedge clk);
    v = req_valid; rv = rsv_valid; ri = rsv_index;
    for (int k = 0; k < NREQ; k++) begin ix[k] = t_idx[k]; dt[k] = t_dat[k]; end
    g = mgrant(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("q0_busy", q0_busy, m_busy[q0_index]);
    chk("q1_busy", q1_busy, m_busy[q1_index]);
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_we  = (ix[g] != 0);
      m_idx = ix[g];
      m_win = dt[g];
      m_busy[ix[g]] = 1'b0;
      m_p = (g + 1) % NREQ;
    end else begin
      m_we = 0;
    end
    if (rv && ri != 0) m_busy[ri] = 1'b1;
    if ($countones(v) >= 2) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    chk("rf_we", rf_we, m_we);
    chk("rf_windex", rf_windex, m_idx);
    chk("rf_win", rf_win, m_win);
    chk("contention_cnt", contention_cnt, m_cnt);
    chk("contention_cnt4", contention_cnt4, m_cnt4);
  endtask

  // Asynchronous reset asserted between edges with all requesters valid.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_windex", rf_windex, 0);
    chk("rst_rf_win", rf_win, 0);
    chk("rst_cnt", contention_cnt, 0);
    chk("rst_cnt4", contention_cnt4, 0);
    chk("rst_ready", req_ready, 1);
    for (int i = 0; i < 32; i++) begin
      q0_index = 5'(i);
      q1_index = 5'(31 - i);
      #1;
      chk("rst_q0_busy", q0_busy, 0);
      chk("rst_q1_busy", q1_busy, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    do_reset();

    // Single write from requester 1
    req_valid = 3'b010; t_idx[1] = 5'd5; t_dat[1] = 32'hDEADBEEF;
    tick();
    chk("single_win", rf_win, 32'hDEADBEEF);
    idle_inputs();
    tick();
    chk("single_we_drop", rf_we, 0);

    // Three requesters contending for three cycles from a fresh reset
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < NREQ; k++) begin t_idx[k] = 5'(k + 1); t_dat[k] = 32'hA000_0000 + k; end
    repeat (3) tick();
    chk("contend3_cnt", contention_cnt, 3);
    idle_inputs();

    // Reserve r7, clear via requester 2, then same-cycle reserve + grant
    rsv_valid = 1; rsv_index = 5'd7; q0_index = 5'd7;
    tick();
    rsv_valid = 0; req_valid = 3'b100; t_idx[2] = 5'd7; t_dat[2] = 32'h0000_0777;
    tick();
    chk("rsv_set_seen", q0_busy, 0);
    idle_inputs(); q0_index = 5'd7;
    tick();
    rsv_valid = 1; rsv_index = 5'd7; q0_index = 5'd7;
    tick();
    req_valid = 3'b100; t_idx[2] = 5'd7; t_dat[2] = 32'h0000_0778;
    tick();
    idle_inputs(); q0_index = 5'd7;
    tick();
    chk("rsv_wins_busy", q0_busy, 1);

    // r0 write is granted but never written; reserving r0 is ignored
    req_valid = 3'b001; t_idx[0] = 5'd0; t_dat[0] = 32'h12345678;
    rsv_valid = 1; rsv_index = 5'd0; q1_index = 5'd0;
    tick();
    chk("r0_we", rf_we, 0);
    idle_inputs();
    tick();
    chk("r0_q1_busy", q1_busy, 0);

    // Saturation of the 4-bit counter
    do_reset();
    req_valid = 3'b011; t_idx[0] = 5'd9; t_idx[1] = 5'd10;
    repeat (20) tick();
    chk("sat_cnt4", contention_cnt4, 15);
    chk("sat_cnt16", contention_cnt, 20);
    idle_inputs();

    // Random traffic, with an asynchronous reset landing mid-run
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        t_idx[k] = 5'($urandom_range(0, 9));
        t_dat[k] = $urandom;
      end
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_index = 5'($urandom_range(0, 9));
      q0_index  = 5'($urandom_range(0, 9));
      q1_index  = 5'($urandom_range(0, 31));
      tick();
      if (n == 200) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
